icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 117 +++++++++++
 tb/tb_icache.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one 32-bit word per line.
//   Lookup happens at the edge where a request is accepted. A hit answers
//   on that edge; a miss raises a request to the memory controller and
//   waits for the fill word.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable (0 freezes every register)
//   clr                  flush: abort outstanding miss, keep array contents
//   IF_S, IF_pos         fetch request valid / word-aligned byte address
//   IF_success, IF_inst  one-cycle response pulse / instruction word
//   IC_S, IC_pos         miss request (level) / miss address
//   IC_success, IC_value fill-done pulse / fill word
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              IF_S,
  input  logic [ADDR_W-1:0] IF_pos,
  output logic              IF_success,
  output logic [31:0]       IF_inst,
  output logic              IC_S,
  output logic [ADDR_W-1:0] IC_pos,
  input  logic              IC_success,
  input  logic [31:0]       IC_value
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0]      req_tag, miss_tag;
  logic                  hit;
  logic                  accept, do_hit, do_miss, do_fill;

  // IC_pos doubles as the latched miss address; it holds while in MISS.
  assign req_idx  = IF_pos[INDEX_BITS+1:2];
  assign req_tag  = IF_pos[ADDR_W-1:INDEX_BITS+2];
  assign miss_idx = IC_pos[INDEX_BITS+1:2];
  assign miss_tag = IC_pos[ADDR_W-1:INDEX_BITS+2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  logic unused_ok;
  assign unused_ok = ^{IF_pos[1:0], IC_pos[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (clr) state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (do_miss) state_nxt = MISS;
      MISS: if (do_fill) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Action decode. The !IF_success term inserts a bubble after every
  // response so a held IF_S is not served twice for the same fetch.
  always_comb begin
    accept  = (state == IDLE) && IF_S && !IF_success;
    do_hit  = accept && hit;
    do_miss = accept && !hit;
    do_fill = (state == MISS) && IC_success;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      IF_success <= 1'b0;
      IF_inst    <= '0;
      IC_S       <= 1'b0;
      IC_pos     <= '0;
    end else if (clr) begin
      IF_success <= 1'b0;
      IC_S       <= 1'b0;
    end else if (rdy) begin
      IF_success <= do_hit || do_fill;
      if (do_hit)  IF_inst <= data_mem[req_idx];
      if (do_fill) IF_inst <= IC_value;
      if (do_miss) begin
        IC_S   <= 1'b1;
        IC_pos <= IF_pos;
      end else if (do_fill) begin
        IC_S   <= 1'b0;
      end
    end
  end

  // Valid bits are the only part of the array that needs reset.
  always_ff @(posedge clk) begin
    if (rst)                        valid <= '0;
    else if (!clr && rdy && do_fill) valid[miss_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && rdy && do_fill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= IC_value;
    end
  end
endmodule

// File: tb/tb_icache.sv
module tb_icache;
  localparam int IB = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, rdy, clr, IF_S, IC_success;
  logic [AW-1:0] IF_pos;
  logic          IF_success, IC_S;
  logic [31:0]   IF_inst, IC_value;
  logic [AW-1:0] IC_pos;

  icache #(.INDEX_BITS(IB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .IF_S(IF_S), .IF_pos(IF_pos), .IF_success(IF_success), .IF_inst(IF_inst),
    .IC_S(IC_S), .IC_pos(IC_pos), .IC_success(IC_success), .IC_value(IC_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: what the cache should hold, keyed by line number.
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];

  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == 22'(a / 1024));
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] v);
    m_valid[line_of(a)] = 1'b1;
    m_tag[line_of(a)]   = 22'(a / 1024);
    m_data[line_of(a)]  = v;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: every new response pulse is matched against the scoreboard.
  bit prev_succ = 1'b0;
  always @(negedge clk) begin
    if (IF_success === 1'b1 && !prev_succ) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got response 0x%08h expected none", IF_inst);
      end else begin
        check("sb_inst", IF_inst, exp_q.pop_front());
      end
    end
    prev_succ = (IF_success === 1'b1);
  end

  // One full fetch: issue, then either expect a hit or serve the miss.
  task automatic do_req(input logic [31:0] a, input logic [31:0] fill, input int dly);
    bit hit;
    hit = model_hit(a);
    exp_q.push_back(hit ? m_data[line_of(a)] : fill);
    @(negedge clk);
    IF_S = 1'b1; IF_pos = a;
    @(negedge clk);
    IF_S = 1'b0;
    if (hit) begin
      check("hit_succ", 32'(IF_success), 32'd1);
      check("hit_no_ics", 32'(IC_S), 32'd0);
    end else begin
      check("miss_ics", 32'(IC_S), 32'd1);
      check("miss_pos", IC_pos, a);
      check("miss_no_succ", 32'(IF_success), 32'd0);
      for (int i = 0; i < dly; i++) begin
        IF_S = 1'b1; IF_pos = $urandom;  // must be ignored while missing
        @(negedge clk);
        check("miss_hold_ics", 32'(IC_S), 32'd1);
        check("miss_hold_pos", IC_pos, a);
      end
      IF_S = 1'b0;
      IC_success = 1'b1; IC_value = fill;
      @(negedge clk);
      IC_success = 1'b0;
      check("fill_succ", 32'(IF_success), 32'd1);
      check("fill_ics", 32'(IC_S), 32'd0);
      model_fill(a, fill);
    end
    @(negedge clk);
    check("succ_pulse", 32'(IF_success), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    model_clear();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; IF_S = 1'b0; IF_pos = '0;
    IC_success = 1'b0; IC_value = '0;
    repeat (3) @(negedge clk);
    check("rst_succ", 32'(IF_success), 32'd0);
    check("rst_inst", IF_inst, 32'd0);
    check("rst_ics", 32'(IC_S), 32'd0);
    check("rst_icpos", IC_pos, 32'd0);
    rst = 1'b0;

    // First fetch after reset misses; fill returns the word.
    do_req(32'h0, 32'h00000513, 0);
    check("fill_inst", IF_inst, 32'h00000513);

    // Held request: answered every other edge, never misses.
    @(negedge clk);
    IF_S = 1'b1; IF_pos = 32'h0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h00000513);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("held_succ", 32'(IF_success), 32'(k % 2));
      check("held_no_ics", 32'(IC_S), 32'd0);
    end
    IF_S = 1'b0;
    @(negedge clk);

    // Same index, different tag evicts the line.
    do_req(32'h400, 32'h00100093, 2);
    check("conflict_inst", IF_inst, 32'h00100093);
    check("model_0_evicted", 32'(model_hit(32'h0)), 32'd0);
    do_req(32'h0, 32'h00000513, 1);

    // Flush during a miss, with a coincident fill that must be dropped.
    @(negedge clk);
    IF_S = 1'b1; IF_pos = 32'h8;
    @(negedge clk);
    IF_S = 1'b0;
    check("clr_pre_ics", 32'(IC_S), 32'd1);
    clr = 1'b1; IC_success = 1'b1; IC_value = 32'hdeadbeef;
    @(negedge clk);
    clr = 1'b0; IC_success = 1'b0;
    check("clr_ics", 32'(IC_S), 32'd0);
    check("clr_succ", 32'(IF_success), 32'd0);
    do_req(32'h8, 32'h11112222, 1);

    // Freeze during a miss; fill pulses while frozen are ignored.
    exp_q.push_back(32'hcafe0001);
    @(negedge clk);
    IF_S = 1'b1; IF_pos = 32'h10;
    @(negedge clk);
    IF_S = 1'b0;
    check("rdy_pre_ics", 32'(IC_S), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      IC_success = (i % 2 == 0); IC_value = 32'hbad0000 + i; IF_S = 1'b1; IF_pos = 32'h0;
      @(negedge clk);
      check("frz_ics", 32'(IC_S), 32'd1);
      check("frz_pos", IC_pos, 32'h10);
      check("frz_succ", 32'(IF_success), 32'd0);
    end
    rdy = 1'b1; IC_success = 1'b0; IF_S = 1'b0;
    @(negedge clk);
    check("thaw_ics", 32'(IC_S), 32'd1);
    IC_success = 1'b1; IC_value = 32'hcafe0001;
    @(negedge clk);
    IC_success = 1'b0;
    check("thaw_succ", 32'(IF_success), 32'd1);
    check("thaw_inst", IF_inst, 32'hcafe0001);
    check("thaw_ics", 32'(IC_S), 32'd0);
    model_fill(32'h10, 32'hcafe0001);
    @(negedge clk);
    do_req(32'h10, 32'h0, 0);

    // Reset in the middle of a miss clears everything.
    @(negedge clk);
    IF_S = 1'b1; IF_pos = 32'h20;
    @(negedge clk);
    IF_S = 1'b0;
    check("rstm_pre_ics", 32'(IC_S), 32'd1);
    rst = 1'b1; rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
    model_clear();
    check("rstm_succ", 32'(IF_success), 32'd0);
    check("rstm_inst", IF_inst, 32'd0);
    check("rstm_ics", 32'(IC_S), 32'd0);
    check("rstm_icpos", IC_pos, 32'd0);
    do_req(32'h0, 32'h00000513, 0);

    // Random traffic over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) a = {$urandom} & 32'hffff_fffc;
      else a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
      do_req(a, $urandom, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
